// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: operand/product registers,
// completion flag, sticky overflow and strobe-protocol checker.
module mul_datapath #(
    parameter int W  = 8,
    parameter int PW = 2 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lda,
    input  logic          ldb,
    input  logic          decb,
    input  logic [W-1:0]  data_in,
    output logic          eq,
    output logic [PW-1:0] product,
    output logic          valid,
    output logic          ovf,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HAVE_A,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [PW-1:0] p_q, p_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic [PW:0]   sum;

    // Extra top bit of sum is the carry out of the product register.
    assign sum = {1'b0, p_q} + {{(PW + 1 - W){1'b0}}, a_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (lda) begin
            a_d     = data_in;
            p_d     = '0;
            ovf_d   = 1'b0;
            state_d = S_HAVE_A;
            if (ldb || decb) begin
                err_d = 1'b1;
            end
        end else begin
            // DONE swallows every trailing strobe silently.
            if (decb && !ldb && state_q != S_DONE) begin
                err_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (ldb || decb) begin
                        err_d = 1'b1;
                    end
                end
                S_HAVE_A: begin
                    if (ldb && !decb) begin
                        b_d     = data_in;
                        state_d = S_RUN;
                    end else if (ldb && decb) begin
                        err_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (ldb && decb) begin
                        if (b_q != '0) begin
                            p_d = sum[PW-1:0];
                            b_d = b_q - ONE;
                            if (sum[PW]) begin
                                ovf_d = 1'b1;
                            end
                            if (b_q == ONE) begin
                                state_d = S_DONE;
                            end
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (ldb) begin
                        b_d = data_in;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign eq      = (b_q == '0);
    assign product = p_q;
    assign valid   = (state_q == S_DONE);
    assign ovf     = ovf_q;
    assign err     = err_q;

endmodule
